// File: rtl/uart_program_loader.sv
// UART (8N1) program loader: packs byte pairs into program words and strobes them
// into program memory at an auto-incrementing address.
module uart_program_loader #(
    parameter int unsigned ADDR_WIDTH        = 8,
    parameter int unsigned INSTRUCTION_WIDTH = 4,
    parameter int unsigned DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter int unsigned CLKS_PER_BIT      = 868,
    parameter int unsigned TIMEOUT_BITS      = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  rewind,
    output logic                  program_write,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic [ADDR_WIDTH-1:0] uart_address,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overflow
);

    localparam int unsigned HiW       = DATA_WIDTH - 8;
    localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
    localparam int unsigned TmoCycles = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TmoW      = $clog2(TmoCycles);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_sync_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            bit_idx_q;
    logic [7:0]            shift_q;
    logic                  phase_q, phase_d;
    logic [HiW-1:0]        b0_q, b0_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q;
    logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;

    logic bit_end, start_mid, data_sample, stop_ok, stop_bad, cnt_clr;
    logic phase_eff, tmo_run, tmo_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!rx_sync_q) state_d = StStart;
            StStart: if (start_mid) state_d = rx_sync_q ? StIdle : StData;
            StData:  if (data_sample && bit_idx_q == 3'd7) state_d = StStop;
            StStop:  if (bit_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bit_end     = (cnt_q == CntW'(CLKS_PER_BIT - 1));
        start_mid   = (state_q == StStart) && (cnt_q == CntW'(CLKS_PER_BIT / 2));
        data_sample = (state_q == StData) && bit_end;
        stop_ok     = (state_q == StStop) && bit_end && rx_sync_q;
        stop_bad    = (state_q == StStop) && bit_end && !rx_sync_q;
        cnt_clr     = (state_q == StIdle) || start_mid ||
                      (((state_q == StData) || (state_q == StStop)) && bit_end);
    end

    // Rewind makes the byte completing this cycle (if any) count as the first of a pair.
    always_comb begin
        cnt_d     = cnt_clr ? '0 : cnt_q + CntW'(1);
        phase_eff = phase_q && !rewind;
        phase_d   = phase_eff;
        b0_d      = b0_q;
        write_d   = 1'b0;
        cmd_d     = cmd_q;
        tmo_run   = phase_q && (state_q == StIdle);
        tmo_hit   = tmo_run && (tmo_cnt_q == TmoW'(TmoCycles - 1));
        tmo_cnt_d = (tmo_run && !tmo_hit) ? tmo_cnt_q + TmoW'(1) : '0;
        if (stop_ok) begin
            if (phase_eff) begin
                write_d = 1'b1;
                cmd_d   = {b0_q, shift_q};
                phase_d = 1'b0;
            end else begin
                b0_d    = shift_q[HiW-1:0];
                phase_d = 1'b1;
            end
        end
        if (stop_bad || tmo_hit) phase_d = 1'b0;
        addr_d = addr_q;
        ovf_d  = ovf_q;
        if (write_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (&addr_q) ovf_d = 1'b1;
        end
        if (rewind) begin
            addr_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            phase_q   <= 1'b0;
            b0_q      <= '0;
            write_q   <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            cnt_q     <= cnt_d;
            if (start_mid) bit_idx_q <= '0;
            if (data_sample) begin
                shift_q   <= {rx_sync_q, shift_q[7:1]};
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            phase_q   <= phase_d;
            b0_q      <= b0_d;
            write_q   <= write_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
            ferr_q    <= stop_bad;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign program_write = write_q;
    assign program_cmd   = cmd_q;
    assign uart_address  = addr_q;
    assign busy          = (state_q != StIdle) || phase_q;
    assign frame_error   = ferr_q;
    assign overflow      = ovf_q;

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Upstream feeder for the processor wrapper's program memory.
- Receives 8N1 serial bytes on one RX line and packs every two bytes into one DATA_WIDTH-bit program word.
- Drives the program write interface: program_write, program_cmd, uart_address.
- Address auto-increments after each word, so a host streams a whole program image starting at address 0.

Parameters:
- ADDR_WIDTH, 8, width of the program address.
- INSTRUCTION_WIDTH, 4, opcode field width.
- DATA_WIDTH, ADDR_WIDTH+INSTRUCTION_WIDTH, program word width; legal range 9..16.
- CLKS_PER_BIT, 868, clk cycles per UART bit; minimum 4.
- TIMEOUT_BITS, 20, idle bit-times after which a half-received word is discarded.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- rx  in  1  asynchronous UART line; idles high.
- rewind  in  1  one-cycle pulse that sets uart_address to 0 and discards any pending byte.
- program_write  out  1  one-cycle write strobe.
- program_cmd  out  DATA_WIDTH  word to write; valid while program_write=1.
- uart_address  out  ADDR_WIDTH  write address; valid while program_write=1.
- busy  out  1  high while a frame or half word is in progress.
- frame_error  out  1  one-cycle pulse when a stop bit is bad.
- overflow  out  1  sticky; set when the address wraps past all-ones. Cleared by reset or rewind.

Behaviour:
- Reset values:
  - Outputs: program_write=0, program_cmd=0, uart_address=0, busy=0, frame_error=0, overflow=0.
  - Internal: RX state IDLE, byte phase 0, both synchronizer flops =1.
- Input synchronizer: rx passes through 2 flops; all sampling uses the synchronized value.
- RX FSM (IDLE, START, DATA, STOP), bit counter 0..CLKS_PER_BIT-1:
  - IDLE: on a synchronized 0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2 (integer), sample the line.
    - If 1, it is a false start: return to IDLE with no byte and no error.
    - If 0, clear the counter and go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the line.
    - If 1, the byte is valid.
    - If 0, pulse frame_error for one cycle, drop the byte, clear byte phase to 0.
    - Either way, return to IDLE.
- Word packing (big-endian):
  - Phase 0 valid byte: b0 is latched and phase goes to 1. Bits [DATA_WIDTH-9:0] of b0 form word[DATA_WIDTH-1:8]; upper unused bits of b0 are ignored.
  - Phase 1 valid byte b1: word = {b0 low bits, b1}. Phase returns to 0.
  - The cycle after the byte completes: program_write=1 for exactly one cycle, with program_cmd=word and uart_address=current address.
  - uart_address increments (mod 2^ADDR_WIDTH) the cycle after the strobe.
  - The increment from all-ones to 0 sets overflow.
- Timeout: in phase 1 with the FSM in IDLE, a counter runs. After TIMEOUT_BITS*CLKS_PER_BIT cycles, phase is cleared to 0 and b0 is discarded, with no pulse. The counter clears on any start bit.
- busy = (FSM != IDLE) or (phase == 1).
- rewind:
  - Takes effect next cycle: address=0, phase=0, overflow=0.
  - An RX frame in progress continues and its byte is treated as phase 0.
  - If rewind coincides with the address increment, rewind wins (address=0).
- reset mid-frame: everything returns to reset values next cycle; the partial frame is lost.
- Back-to-back frames (stop bit followed immediately by a start bit) must be received without loss.
- Minimum spacing between program_write pulses is 20*CLKS_PER_BIT cycles.

Test Plan (CLKS_PER_BIT=4, TIMEOUT_BITS=20, defaults otherwise):
1. After reset, send bytes 0x03, 0xA5 -> exactly one program_write pulse with program_cmd=0x3A5, uart_address=0x00. Afterwards uart_address=0x01, busy=0.
2. Stream 6 back-to-back bytes 0x01,0x10,0x02,0x20,0x0F,0xFF -> pulses at addresses 0,1,2 with cmd 0x110, 0x220, 0xFFF. No frame_error.
3. Send 0x05, then a frame with stop bit=0, then 0x07, 0x08 -> one frame_error pulse and no write for the bad pair. The next write has cmd=0x708 at address 0.
4. Send 0x04, then idle 90 cycles, then 0x06, 0x09 -> the first byte is discarded by timeout. Write cmd=0x609 at address 0. busy=0 during the tail of the idle gap.
5. Glitch rx low for 1 bit-time/4 -> no byte, no error, FSM back in IDLE. Then preload the address to 0xFF with 255 words, write one more -> write at 0xFF, address wraps to 0x00, overflow=1.
6. Assert rewind between the two bytes of a word, and separately assert reset mid-DATA -> next valid pair writes at address 0; all outputs match reset values the cycle after reset.
